qpu_exu_alu_arb: RTL and testbench
==================================

Name: qpu_exu_alu_arb

Overview:
- Arbitration and result-register stage in front of the shared ALU datapath. Three requestors use it: ALU instructions, BJP compare, and QIU timing-label add.
- Each cycle it grants at most one request round-robin, drives the datapath's one-hot request select, operands and op flags, and captures the datapath result into a one-entry output register.
- The output register is handed to EXU writeback over a valid/ready handshake. Latency is one cycle; sustained throughput is one request per cycle.

Parameters:
XLEN, 32, operand/result width (matches QPU_XLEN)
TAG_W, 5, width of the requestor tag carried alongside each request

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
alu_i_valid  in  1  ALU request valid
alu_i_ready  out  1  ALU request accepted this cycle
alu_i_op  in  5  one-hot {add,sub,xor,or,and}
alu_i_op1  in  XLEN  ALU operand 1
alu_i_op2  in  XLEN  ALU operand 2
alu_i_tag  in  TAG_W  ALU request tag
bjp_i_valid  in  1  BJP request valid
bjp_i_ready  out  1  BJP request accepted this cycle
bjp_i_cmp  in  4  one-hot {eq,ne,lt,gt}
bjp_i_op1  in  XLEN  BJP operand 1
bjp_i_op2  in  XLEN  BJP operand 2
bjp_i_tag  in  TAG_W  BJP request tag
qiu_i_valid  in  1  QIU request valid
qiu_i_ready  out  1  QIU request accepted this cycle
qiu_i_op1  in  XLEN  QIU operand 1
qiu_i_op2  in  XLEN  QIU operand 2
qiu_i_tag  in  TAG_W  QIU request tag
dp_sel  out  3  one-hot {alu,bjp,qiu} request-select to the datapath
dp_op1  out  XLEN  muxed operand 1 to the datapath
dp_op2  out  XLEN  muxed operand 2 to the datapath
dp_alu_op  out  5  ALU op flags to the datapath, zero unless ALU is granted
dp_cmp_op  out  4  compare flags to the datapath, zero unless BJP is granted
dp_res  in  XLEN  datapath arithmetic/logic result
dp_cmp_res  in  1  datapath compare result
o_valid  out  1  result register valid
o_ready  in  1  writeback accepts the result
o_res  out  XLEN  registered result
o_cmp  out  1  registered compare result
o_src  out  2  source of the result: 0=ALU, 1=BJP, 2=QIU
o_tag  out  TAG_W  registered request tag

Behaviour:
- Reset values (asynchronous on rst_n low):
  - o_valid=0; o_res, o_cmp, o_tag = 0; o_src=0.
  - Round-robin pointer = ALU.
  - No grant is issued while rst_n is low.
- can_accept = ~o_valid | o_ready.
  - A grant is issued only when can_accept=1 and at least one *_i_valid=1.
- Arbitration:
  - Round-robin over the fixed order ALU→BJP→QIU.
  - Search starts at the pointer; the first valid requestor is granted.
  - After a grant, the pointer moves to the requestor following the granted one.
  - With no grant, the pointer holds.
- Grant and ready:
  - X_i_ready = grant_X (combinational); at most one ready is high per cycle.
  - Requestors hold valid and payload stable until ready.
  - Readiness does not depend on the requestor's own valid beyond grant selection.
- Datapath drive (combinational in the grant cycle):
  - dp_sel = one-hot grant, or 0 with no grant.
  - dp_op1/dp_op2 = granted operands, 0 with no grant.
  - dp_alu_op and dp_cmp_op are forced to 0 when their requestor is not granted.
- Capture (on the clock edge of the grant cycle):
  - o_valid=1; o_res=dp_res; o_src and o_tag from the granted requestor.
  - o_cmp = dp_cmp_res when BJP is granted, otherwise 0.
- Drain: o_valid=1 & o_ready=1 with no new grant → o_valid=0 next cycle. Payload registers hold their value; they are not cleared.
- Simultaneous drain and grant in the same cycle → the new result replaces the old one and o_valid stays 1. This gives back-to-back throughput with no bubble.
- Back-pressure: o_valid=1 & o_ready=0 → no grant, all *_i_ready=0, output payload is stable. The pointer does not advance.
- Illegal inputs: more than one bit set in alu_i_op or bjp_i_cmp is illegal. The behaviour is then undefined; the bench asserts against it.
- Reset mid-operation: a held result is dropped (o_valid→0 asynchronously) and the pointer returns to ALU.
  - A request that has not been accepted must be re-presented after reset.
  - The block stores no other state.

Decomposition:
- Shared package (QPU_defines): XLEN, TAG_W, the source encodings SRC_ALU=0, SRC_BJP=1, SRC_QIU=2, and the op-flag bit positions.
- Natural sub-module: qpu_exu_alu_rr_arb, a 3-way round-robin arbiter holding the pointer.
  - Inputs: req[2:0], en (= can_accept).
  - Output: one-hot gnt[2:0].
- The capture register and muxes stay in the top module.

Test Plan:
1. After reset, ALU add with op1=5, op2=7 and o_ready=1 → alu_i_ready=1 in the same cycle. Next cycle: o_valid=1, o_res=12, o_src=0, o_tag echoes the ALU tag.
2. All three valid for 6 cycles with o_ready=1 → grants go ALU, BJP, QIU, ALU, BJP, QIU, exactly one ready per cycle. o_valid stays 1 with no bubbles.
3. BJP lt with op1=0xFFFFFFFF (-1) and op2=1 → o_cmp=1, o_src=1. BJP eq with op1=op2=0x1234 → o_cmp=1. BJP ne with equal operands → o_cmp=0.
4. o_ready=0 for 3 cycles while BJP holds valid, with a result already held → all readies 0 and o_res stable. When o_ready rises, BJP is granted that same cycle and its result appears the next cycle.
5. QIU op1=0x7FFFFFFF, op2=1 → o_res=0x80000000 (wrap-around, no saturation), o_cmp=0, o_src=2.
6. Assert rst_n low while o_valid=1 → o_valid=0 immediately. After release, with ALU and QIU both valid, the first grant goes to ALU.

Source files
------------

// File: rtl/qpu_exu_alu_arb_pkg.sv
// Shared definitions for the EXU ALU arbitration stage: widths, source encodings
// and bit positions of the one-hot op/compare/select flags.
package qpu_exu_alu_arb_pkg;

  localparam int QPU_XLEN  = 32;
  localparam int QPU_TAG_W = 5;

  localparam int ALU_OP_W = 5;
  localparam int CMP_OP_W = 4;
  localparam int NUM_REQ  = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_BJP = 2'd1,
    SRC_QIU = 2'd2
  } src_e;

  // dp_sel / request vector layout is {alu, bjp, qiu}
  localparam int SEL_ALU = 2;
  localparam int SEL_BJP = 1;
  localparam int SEL_QIU = 0;

  // alu op layout is {add, sub, xor, or, and}
  localparam int ALU_OP_ADD = 4;
  localparam int ALU_OP_SUB = 3;
  localparam int ALU_OP_XOR = 2;
  localparam int ALU_OP_OR  = 1;
  localparam int ALU_OP_AND = 0;

  // compare layout is {eq, ne, lt, gt}
  localparam int CMP_EQ = 3;
  localparam int CMP_NE = 2;
  localparam int CMP_LT = 1;
  localparam int CMP_GT = 0;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    case (s)
      SRC_ALU: next_src = SRC_BJP;
      SRC_BJP: next_src = SRC_QIU;
      default: next_src = SRC_ALU;
    endcase
  endfunction

  function automatic int sel_bit(input logic [1:0] s);
    case (s)
      SRC_ALU: sel_bit = SEL_ALU;
      SRC_BJP: sel_bit = SEL_BJP;
      default: sel_bit = SEL_QIU;
    endcase
  endfunction

endpackage

// File: rtl/qpu_exu_alu_rr_arb.sv
// Three-way round-robin arbiter (ALU -> BJP -> QIU). Holds the search pointer,
// which advances past the winner only when a grant is actually issued.
module qpu_exu_alu_rr_arb
  import qpu_exu_alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] gnt
);

  logic [1:0] ptr;
  logic [1:0] win;
  logic [1:0] cand;
  logic       hit;
  logic       req_by_src [NUM_REQ];

  always_comb begin
    req_by_src[SRC_ALU] = req[SEL_ALU];
    req_by_src[SRC_BJP] = req[SEL_BJP];
    req_by_src[SRC_QIU] = req[SEL_QIU];
  end

  always_comb begin
    hit  = 1'b0;
    win  = ptr;
    cand = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && req_by_src[cand]) begin
        hit = 1'b1;
        win = cand;
      end
      cand = next_src(cand);
    end
  end

  always_comb begin
    gnt = '0;
    if (en && hit) gnt[sel_bit(win)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SRC_ALU;
    end else if (en && hit) begin
      ptr <= next_src(win);
    end
  end

endmodule

// File: rtl/qpu_exu_alu_arb.sv
// Arbitration and result-register stage in front of the shared ALU datapath:
// grants one of ALU/BJP/QIU per cycle, drives the datapath, registers its result.
module qpu_exu_alu_arb
  import qpu_exu_alu_arb_pkg::*;
#(
  parameter int XLEN  = QPU_XLEN,
  parameter int TAG_W = QPU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             alu_i_valid,
  output logic             alu_i_ready,
  input  logic [4:0]       alu_i_op,
  input  logic [XLEN-1:0]  alu_i_op1,
  input  logic [XLEN-1:0]  alu_i_op2,
  input  logic [TAG_W-1:0] alu_i_tag,

  input  logic             bjp_i_valid,
  output logic             bjp_i_ready,
  input  logic [3:0]       bjp_i_cmp,
  input  logic [XLEN-1:0]  bjp_i_op1,
  input  logic [XLEN-1:0]  bjp_i_op2,
  input  logic [TAG_W-1:0] bjp_i_tag,

  input  logic             qiu_i_valid,
  output logic             qiu_i_ready,
  input  logic [XLEN-1:0]  qiu_i_op1,
  input  logic [XLEN-1:0]  qiu_i_op2,
  input  logic [TAG_W-1:0] qiu_i_tag,

  output logic [2:0]       dp_sel,
  output logic [XLEN-1:0]  dp_op1,
  output logic [XLEN-1:0]  dp_op2,
  output logic [4:0]       dp_alu_op,
  output logic [3:0]       dp_cmp_op,
  input  logic [XLEN-1:0]  dp_res,
  input  logic             dp_cmp_res,

  output logic             o_valid,
  input  logic             o_ready,
  output logic [XLEN-1:0]  o_res,
  output logic             o_cmp,
  output logic [1:0]       o_src,
  output logic [TAG_W-1:0] o_tag
);

  logic             can_accept;
  logic             arb_en;
  logic [2:0]       req;
  logic [2:0]       gnt;
  logic             any_gnt;
  logic [1:0]       gnt_src;
  logic [TAG_W-1:0] gnt_tag;

  assign can_accept = ~o_valid | o_ready;
  // rst_n gates the arbiter so no requestor sees ready while reset is asserted
  assign arb_en     = can_accept & rst_n;
  assign req        = {alu_i_valid, bjp_i_valid, qiu_i_valid};

  qpu_exu_alu_rr_arb u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign any_gnt     = |gnt;
  assign alu_i_ready = gnt[SEL_ALU];
  assign bjp_i_ready = gnt[SEL_BJP];
  assign qiu_i_ready = gnt[SEL_QIU];
  assign dp_sel      = gnt;

  always_comb begin
    dp_op1    = '0;
    dp_op2    = '0;
    dp_alu_op = '0;
    dp_cmp_op = '0;
    gnt_src   = SRC_ALU;
    gnt_tag   = '0;
    if (gnt[SEL_ALU]) begin
      dp_op1    = alu_i_op1;
      dp_op2    = alu_i_op2;
      dp_alu_op = alu_i_op;
      gnt_src   = SRC_ALU;
      gnt_tag   = alu_i_tag;
    end else if (gnt[SEL_BJP]) begin
      dp_op1    = bjp_i_op1;
      dp_op2    = bjp_i_op2;
      dp_cmp_op = bjp_i_cmp;
      gnt_src   = SRC_BJP;
      gnt_tag   = bjp_i_tag;
    end else if (gnt[SEL_QIU]) begin
      dp_op1    = qiu_i_op1;
      dp_op2    = qiu_i_op2;
      gnt_src   = SRC_QIU;
      gnt_tag   = qiu_i_tag;
    end
  end

  // A grant in the same cycle as a drain simply overwrites the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_res   <= '0;
      o_cmp   <= 1'b0;
      o_src   <= SRC_ALU;
      o_tag   <= '0;
    end else if (any_gnt) begin
      o_valid <= 1'b1;
      o_res   <= dp_res;
      o_cmp   <= gnt[SEL_BJP] & dp_cmp_res;
      o_src   <= gnt_src;
      o_tag   <= gnt_tag;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpu_exu_alu_arb.sv
// Directed bench for qpu_exu_alu_arb; a behavioural datapath closes the dp_* loop.
module tb_qpu_exu_alu_arb;
  import qpu_exu_alu_arb_pkg::*;

  localparam int XLEN  = QPU_XLEN;
  localparam int TAG_W = QPU_TAG_W;

  logic             clk;
  logic             rst_n;
  logic             alu_i_valid, alu_i_ready;
  logic [4:0]       alu_i_op;
  logic [XLEN-1:0]  alu_i_op1, alu_i_op2;
  logic [TAG_W-1:0] alu_i_tag;
  logic             bjp_i_valid, bjp_i_ready;
  logic [3:0]       bjp_i_cmp;
  logic [XLEN-1:0]  bjp_i_op1, bjp_i_op2;
  logic [TAG_W-1:0] bjp_i_tag;
  logic             qiu_i_valid, qiu_i_ready;
  logic [XLEN-1:0]  qiu_i_op1, qiu_i_op2;
  logic [TAG_W-1:0] qiu_i_tag;
  logic [2:0]       dp_sel;
  logic [XLEN-1:0]  dp_op1, dp_op2;
  logic [4:0]       dp_alu_op;
  logic [3:0]       dp_cmp_op;
  logic [XLEN-1:0]  dp_res;
  logic             dp_cmp_res;
  logic             o_valid, o_ready;
  logic [XLEN-1:0]  o_res;
  logic             o_cmp;
  logic [1:0]       o_src;
  logic [TAG_W-1:0] o_tag;

  int total  = 0;
  int passed = 0;

  qpu_exu_alu_arb #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready), .alu_i_op(alu_i_op),
    .alu_i_op1(alu_i_op1), .alu_i_op2(alu_i_op2), .alu_i_tag(alu_i_tag),
    .bjp_i_valid(bjp_i_valid), .bjp_i_ready(bjp_i_ready), .bjp_i_cmp(bjp_i_cmp),
    .bjp_i_op1(bjp_i_op1), .bjp_i_op2(bjp_i_op2), .bjp_i_tag(bjp_i_tag),
    .qiu_i_valid(qiu_i_valid), .qiu_i_ready(qiu_i_ready),
    .qiu_i_op1(qiu_i_op1), .qiu_i_op2(qiu_i_op2), .qiu_i_tag(qiu_i_tag),
    .dp_sel(dp_sel), .dp_op1(dp_op1), .dp_op2(dp_op2),
    .dp_alu_op(dp_alu_op), .dp_cmp_op(dp_cmp_op),
    .dp_res(dp_res), .dp_cmp_res(dp_cmp_res),
    .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res), .o_cmp(o_cmp),
    .o_src(o_src), .o_tag(o_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared datapath
  always_comb begin
    dp_res     = '0;
    dp_cmp_res = 1'b0;
    if (dp_alu_op[ALU_OP_ADD]) dp_res = dp_op1 + dp_op2;
    if (dp_alu_op[ALU_OP_SUB]) dp_res = dp_op1 - dp_op2;
    if (dp_alu_op[ALU_OP_XOR]) dp_res = dp_op1 ^ dp_op2;
    if (dp_alu_op[ALU_OP_OR])  dp_res = dp_op1 | dp_op2;
    if (dp_alu_op[ALU_OP_AND]) dp_res = dp_op1 & dp_op2;
    if (dp_sel[SEL_QIU])       dp_res = dp_op1 + dp_op2;
    if (dp_sel[SEL_BJP])       dp_res = dp_op1 - dp_op2;
    if (dp_cmp_op[CMP_EQ]) dp_cmp_res = (dp_op1 == dp_op2);
    if (dp_cmp_op[CMP_NE]) dp_cmp_res = (dp_op1 != dp_op2);
    if (dp_cmp_op[CMP_LT]) dp_cmp_res = ($signed(dp_op1) < $signed(dp_op2));
    if (dp_cmp_op[CMP_GT]) dp_cmp_res = ($signed(dp_op1) > $signed(dp_op2));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_i_valid) assert ($onehot(alu_i_op)) else $error("illegal alu_i_op %b", alu_i_op);
      if (bjp_i_valid) assert ($onehot(bjp_i_cmp)) else $error("illegal bjp_i_cmp %b", bjp_i_cmp);
      assert ($onehot0({alu_i_ready, bjp_i_ready, qiu_i_ready})) else $error("multiple readies");
    end
  end

  task automatic clear_inputs();
    alu_i_valid = 0; alu_i_op = '0; alu_i_op1 = '0; alu_i_op2 = '0; alu_i_tag = '0;
    bjp_i_valid = 0; bjp_i_cmp = '0; bjp_i_op1 = '0; bjp_i_op2 = '0; bjp_i_tag = '0;
    qiu_i_valid = 0; qiu_i_op1 = '0; qiu_i_op2 = '0; qiu_i_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    o_ready = 1;
    rst_n = 0;
    alu_i_valid = 1; alu_i_op = 5'b10000;
    step();
    total++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid got %0b want 0", o_valid); else passed++;
    total++; if (o_res !== '0) $display("FAIL reset_o_res got %h want 0", o_res); else passed++;
    total++; if ({o_cmp, o_src, o_tag} !== '0) $display("FAIL reset_payload got %b want 0", {o_cmp, o_src, o_tag}); else passed++;
    total++; if (alu_i_ready !== 1'b0) $display("FAIL reset_no_grant got %0b want 0", alu_i_ready); else passed++;
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_alu_add();
    alu_i_valid = 1; alu_i_op = 5'b10000; alu_i_op1 = 5; alu_i_op2 = 7; alu_i_tag = 5'd3;
    o_ready = 1;
    #1;
    total++; if ({alu_i_ready, bjp_i_ready, qiu_i_ready} !== 3'b100) $display("FAIL alu_ready got %b want 100", {alu_i_ready, bjp_i_ready, qiu_i_ready}); else passed++;
    total++; if (dp_sel !== 3'b100 || dp_alu_op !== 5'b10000 || dp_cmp_op !== 4'b0) $display("FAIL alu_dp_drive got sel=%b alu=%b cmp=%b", dp_sel, dp_alu_op, dp_cmp_op); else passed++;
    step();
    clear_inputs();
    total++; if (o_valid !== 1'b1 || o_res !== 32'd12) $display("FAIL alu_result got v=%0b res=%0d want v=1 res=12", o_valid, o_res); else passed++;
    total++; if (o_src !== 2'd0 || o_tag !== 5'd3) $display("FAIL alu_src_tag got src=%0d tag=%0d want 0/3", o_src, o_tag); else passed++;
    #1;
    total++; if (dp_sel !== 3'b000 || dp_op1 !== '0) $display("FAIL idle_dp got sel=%b op1=%h want 0", dp_sel, dp_op1); else passed++;
    step();
    total++; if (o_valid !== 1'b0 || o_res !== 32'd12) $display("FAIL drain got v=%0b res=%0d want v=0 res=12", o_valid, o_res); else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0]       exp_rdy [3];
    logic [TAG_W-1:0] tags [3];
    exp_rdy[0] = 3'b100; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b001;
    tags[0] = 5'd1; tags[1] = 5'd2; tags[2] = 5'd4;
    do_reset();
    o_ready = 1;
    alu_i_valid = 1; alu_i_op = 5'b01000; alu_i_op1 = 20; alu_i_op2 = 5; alu_i_tag = tags[0];
    bjp_i_valid = 1; bjp_i_cmp = 4'b0001; bjp_i_op1 = 3; bjp_i_op2 = 2; bjp_i_tag = tags[1];
    qiu_i_valid = 1; qiu_i_op1 = 100; qiu_i_op2 = 1; qiu_i_tag = tags[2];
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if ({alu_i_ready, bjp_i_ready, qiu_i_ready} !== exp_rdy[i%3]) $display("FAIL rr_ready[%0d] got %b want %b", i, {alu_i_ready, bjp_i_ready, qiu_i_ready}, exp_rdy[i%3]); else passed++;
      step();
      total++; if (o_valid !== 1'b1 || o_src !== 2'(i%3) || o_tag !== tags[i%3]) $display("FAIL rr_out[%0d] got v=%0b src=%0d tag=%0d want v=1 src=%0d tag=%0d", i, o_valid, o_src, o_tag, i%3, tags[i%3]); else passed++;
      case (i % 3)
        0: begin total++; if (o_res !== 32'd15 || o_cmp !== 1'b0) $display("FAIL rr_alu_res[%0d] got %0d/%0b want 15/0", i, o_res, o_cmp); else passed++; end
        1: begin total++; if (o_cmp !== 1'b1) $display("FAIL rr_bjp_cmp[%0d] got %0b want 1", i, o_cmp); else passed++; end
        default: begin total++; if (o_res !== 32'd101 || o_cmp !== 1'b0) $display("FAIL rr_qiu_res[%0d] got %0d/%0b want 101/0", i, o_res, o_cmp); else passed++; end
      endcase
    end
    clear_inputs();
    step();
  endtask

  task automatic test_bjp_cmp();
    logic [3:0]      cmps [4];
    logic [XLEN-1:0] a [4];
    logic [XLEN-1:0] b [4];
    logic            exp [4];
    cmps[0] = 4'b0010; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1;     exp[0] = 1'b1;
    cmps[1] = 4'b1000; a[1] = 32'h1234;      b[1] = 32'h1234;  exp[1] = 1'b1;
    cmps[2] = 4'b0100; a[2] = 32'h1234;      b[2] = 32'h1234;  exp[2] = 1'b0;
    cmps[3] = 4'b0001; a[3] = 32'hFFFF_FFFF; b[3] = 32'd1;     exp[3] = 1'b0;
    o_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bjp_i_valid = 1; bjp_i_cmp = cmps[i]; bjp_i_op1 = a[i]; bjp_i_op2 = b[i]; bjp_i_tag = 5'(10 + i);
      #1;
      total++; if (bjp_i_ready !== 1'b1 || dp_cmp_op !== cmps[i] || dp_alu_op !== 5'b0) $display("FAIL bjp_drive[%0d] got rdy=%0b cmp=%b alu=%b", i, bjp_i_ready, dp_cmp_op, dp_alu_op); else passed++;
      step();
      total++; if (o_cmp !== exp[i] || o_src !== 2'd1 || o_tag !== 5'(10 + i)) $display("FAIL bjp_cmp[%0d] got cmp=%0b src=%0d tag=%0d want cmp=%0b src=1 tag=%0d", i, o_cmp, o_src, o_tag, exp[i], 10 + i); else passed++;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_backpressure();
    o_ready = 1;
    alu_i_valid = 1; alu_i_op = 5'b00100; alu_i_op1 = 32'hF0F0; alu_i_op2 = 32'h0FF0; alu_i_tag = 5'd7;
    step();
    clear_inputs();
    o_ready = 0;
    bjp_i_valid = 1; bjp_i_cmp = 4'b1000; bjp_i_op1 = 9; bjp_i_op2 = 9; bjp_i_tag = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({alu_i_ready, bjp_i_ready, qiu_i_ready} !== 3'b000 || dp_sel !== 3'b000) $display("FAIL bp_ready[%0d] got rdy=%b sel=%b want 0", i, {alu_i_ready, bjp_i_ready, qiu_i_ready}, dp_sel); else passed++;
      total++; if (o_valid !== 1'b1 || o_res !== 32'hFF00 || o_tag !== 5'd7) $display("FAIL bp_hold[%0d] got v=%0b res=%h tag=%0d want 1/ff00/7", i, o_valid, o_res, o_tag); else passed++;
      step();
    end
    o_ready = 1;
    #1;
    total++; if (bjp_i_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", bjp_i_ready); else passed++;
    step();
    clear_inputs();
    total++; if (o_valid !== 1'b1 || o_src !== 2'd1 || o_cmp !== 1'b1 || o_tag !== 5'd9) $display("FAIL bp_release_out got v=%0b src=%0d cmp=%0b tag=%0d want 1/1/1/9", o_valid, o_src, o_cmp, o_tag); else passed++;
    step();
    total++; if (o_valid !== 1'b0) $display("FAIL bp_drain got %0b want 0", o_valid); else passed++;
  endtask

  task automatic test_qiu_wrap();
    o_ready = 1;
    qiu_i_valid = 1; qiu_i_op1 = 32'h7FFF_FFFF; qiu_i_op2 = 32'd1; qiu_i_tag = 5'd5;
    #1;
    total++; if (qiu_i_ready !== 1'b1 || dp_sel !== 3'b001 || dp_alu_op !== 5'b0) $display("FAIL qiu_drive got rdy=%0b sel=%b alu=%b", qiu_i_ready, dp_sel, dp_alu_op); else passed++;
    step();
    clear_inputs();
    total++; if (o_res !== 32'h8000_0000 || o_cmp !== 1'b0 || o_src !== 2'd2 || o_tag !== 5'd5) $display("FAIL qiu_wrap got res=%h cmp=%0b src=%0d tag=%0d want 80000000/0/2/5", o_res, o_cmp, o_src, o_tag); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    o_ready = 1;
    alu_i_valid = 1; alu_i_op = 5'b10000; alu_i_op1 = 1; alu_i_op2 = 1; alu_i_tag = 5'd2;
    step();
    clear_inputs();
    o_ready = 0;
    #2;
    total++; if (o_valid !== 1'b1) $display("FAIL rst_mid_pre got %0b want 1", o_valid); else passed++;
    rst_n = 0;
    #1;
    total++; if (o_valid !== 1'b0 || o_res !== '0) $display("FAIL rst_mid_async got v=%0b res=%h want 0/0", o_valid, o_res); else passed++;
    o_ready = 1;
    alu_i_valid = 1; alu_i_op = 5'b10000; alu_i_op1 = 2; alu_i_op2 = 3; alu_i_tag = 5'd6;
    qiu_i_valid = 1; qiu_i_op1 = 10; qiu_i_op2 = 20; qiu_i_tag = 5'd8;
    #1;
    total++; if ({alu_i_ready, qiu_i_ready} !== 2'b00) $display("FAIL rst_mid_nogrant got %b want 00", {alu_i_ready, qiu_i_ready}); else passed++;
    step();
    rst_n = 1;
    #1;
    total++; if ({alu_i_ready, bjp_i_ready, qiu_i_ready} !== 3'b100) $display("FAIL rst_mid_first got %b want 100", {alu_i_ready, bjp_i_ready, qiu_i_ready}); else passed++;
    step();
    alu_i_valid = 0;
    total++; if (o_valid !== 1'b1 || o_src !== 2'd0 || o_res !== 32'd5) $display("FAIL rst_mid_alu_out got v=%0b src=%0d res=%0d want 1/0/5", o_valid, o_src, o_res); else passed++;
    #1;
    total++; if (qiu_i_ready !== 1'b1) $display("FAIL rst_mid_qiu_ready got %0b want 1", qiu_i_ready); else passed++;
    step();
    clear_inputs();
    total++; if (o_src !== 2'd2 || o_res !== 32'd30 || o_tag !== 5'd8) $display("FAIL rst_mid_qiu_out got src=%0d res=%0d tag=%0d want 2/30/8", o_src, o_res, o_tag); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_round_robin();
    test_bjp_cmp();
    test_backpressure();
    test_qiu_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
